// File: rtl/button_hold_detector.sv
// button_hold_detector: per-channel synchronised, debounced short-press / hold / auto-repeat detector
module button_hold_detector #(
    parameter int N_CH         = 4,
    parameter int TICKS_PER_MS = 1,
    parameter int DEBOUNCE_MS  = 20,
    parameter int HOLD_MS      = 5000,
    parameter int REPEAT_MS    = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] btn_raw,
    input  logic [N_CH-1:0] ch_en,
    output logic [N_CH-1:0] pressed,
    output logic [N_CH-1:0] short_pulse,
    output logic [N_CH-1:0] hold_pulse,
    output logic [N_CH-1:0] hold_level,
    output logic [N_CH-1:0] repeat_pulse
);
    localparam int DB = DEBOUNCE_MS * TICKS_PER_MS;
    localparam int HT = HOLD_MS * TICKS_PER_MS;
    localparam int RT = REPEAT_MS * TICKS_PER_MS;
    localparam int W  = $clog2(((HT > RT) ? HT : RT) + 1);
    localparam logic [W-1:0] DB_W = W'(DB);
    localparam logic [W-1:0] HT_W = W'(HT);
    localparam logic [W-1:0] RT_W = W'(RT);
    localparam logic [W-1:0] ONE  = W'(1);

    typedef enum logic [2:0] {IDLE, DB_PRESS, PRESSED, HELD, DB_REL} state_t;

    logic [1:0]      rst_sync;
    logic            rst_n;
    logic [N_CH-1:0] sync_a, sync_s;

    // Reset asserts immediately and releases two clocks after the pin deasserts
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end

    assign rst_n = rst_sync[1];

    // Two-flop synchroniser for the asynchronous button levels
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a <= '0;
            sync_s <= '0;
        end else begin
            sync_a <= btn_raw;
            sync_s <= sync_a;
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        state_t       state, state_nx;
        logic         from_held, from_held_nx;
        logic [W-1:0] cnt, cnt_nx, rcnt, rcnt_nx, rpt, rpt_nx, cnt_inc;
        logic         sp_nx, hp_nx, rp_nx, sp_q, hp_q, rp_q;
        logic         s;

        assign s       = sync_s[c];
        assign cnt_inc = (cnt == HT_W) ? cnt : cnt + ONE;

        // Next state, press/release/repeat counters and pulse decode
        always_comb begin
            state_nx     = state;
            from_held_nx = from_held;
            cnt_nx       = cnt;
            rcnt_nx      = rcnt;
            rpt_nx       = rpt;
            sp_nx        = 1'b0;
            hp_nx        = 1'b0;
            rp_nx        = 1'b0;
            case (state)
                IDLE: begin
                    state_nx = s ? DB_PRESS : IDLE;
                    cnt_nx   = s ? ONE : '0;
                end
                DB_PRESS: begin
                    state_nx = s ? DB_PRESS : IDLE;
                    cnt_nx   = s ? cnt_inc : '0;
                end
                PRESSED: begin
                    cnt_nx = cnt_inc;
                    if (!s) begin
                        state_nx     = DB_REL;
                        rcnt_nx      = ONE;
                        from_held_nx = 1'b0;
                    end else if (cnt_inc == HT_W) begin
                        state_nx = HELD;
                        hp_nx    = 1'b1;
                        rpt_nx   = '0;
                    end
                end
                HELD: begin
                    cnt_nx = cnt_inc;
                    if (!s) begin
                        state_nx     = DB_REL;
                        rcnt_nx      = ONE;
                        from_held_nx = 1'b1;
                    end else if (RT > 0) begin
                        rp_nx  = (rpt + ONE == RT_W);
                        rpt_nx = rp_nx ? '0 : rpt + ONE;
                    end
                end
                DB_REL: begin
                    cnt_nx   = cnt_inc;
                    state_nx = s ? (from_held ? HELD : PRESSED) : DB_REL;
                    rcnt_nx  = s ? '0 : ((rcnt == DB_W) ? rcnt : rcnt + ONE);
                end
                default: state_nx = IDLE;
            endcase
            // Debounce completion is resolved after the case so a one-tick debounce settles on the first sample
            if (state_nx == DB_PRESS && cnt_nx == DB_W) state_nx = PRESSED;
            if (state_nx == DB_REL && rcnt_nx == DB_W) begin
                state_nx     = IDLE;
                sp_nx        = !from_held_nx;
                cnt_nx       = '0;
                rcnt_nx      = '0;
                rpt_nx       = '0;
                from_held_nx = 1'b0;
            end
            if (!ch_en[c]) begin
                state_nx     = IDLE;
                from_held_nx = 1'b0;
                cnt_nx       = '0;
                rcnt_nx      = '0;
                rpt_nx       = '0;
                sp_nx        = 1'b0;
                hp_nx        = 1'b0;
                rp_nx        = 1'b0;
            end
        end

        // Channel state, counters and registered one-cycle pulses
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state     <= IDLE;
                from_held <= 1'b0;
                cnt       <= '0;
                rcnt      <= '0;
                rpt       <= '0;
                sp_q      <= 1'b0;
                hp_q      <= 1'b0;
                rp_q      <= 1'b0;
            end else begin
                state     <= state_nx;
                from_held <= from_held_nx;
                cnt       <= cnt_nx;
                rcnt      <= rcnt_nx;
                rpt       <= rpt_nx;
                sp_q      <= sp_nx;
                hp_q      <= hp_nx;
                rp_q      <= rp_nx;
            end
        end

        assign pressed[c]      = (state == PRESSED) || (state == HELD) || (state == DB_REL);
        assign hold_level[c]   = (state == HELD) || ((state == DB_REL) && from_held);
        assign short_pulse[c]  = sp_q;
        assign hold_pulse[c]   = hp_q;
        assign repeat_pulse[c] = rp_q;
    end
endmodule

// File: tb/tb_button_hold_detector.sv
// tb_button_hold_detector: directed press/hold scenarios checked against a timestamp-based model
module tb_button_hold_detector;
    localparam int DB = 20;
    localparam int HT = 5000;
    localparam int RT = 500;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] btn_raw = '0;
    logic [3:0] ch_en = '1;
    logic [3:0] pressed, short_pulse, hold_pulse, hold_level, repeat_pulse;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    button_hold_detector #(
        .N_CH(4), .TICKS_PER_MS(1), .DEBOUNCE_MS(DB), .HOLD_MS(HT), .REPEAT_MS(RT)
    ) dut (
        .clk(clk), .reset(reset), .btn_raw(btn_raw), .ch_en(ch_en),
        .pressed(pressed), .short_pulse(short_pulse), .hold_pulse(hold_pulse),
        .hold_level(hold_level), .repeat_pulse(repeat_pulse)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Model: debounced level from run lengths of the 2-cycle-delayed input, hold/repeat from timestamps
    logic [3:0] hist [0:65535];
    logic [3:0] m_pr = '0, m_sp = '0, m_hp = '0, m_hl = '0, m_rp = '0;
    int  rc = 0, a = 0, pre = 0;
    int  run [4], st [4], hcnt [4];
    bit  lvl [4], held [4];
    logic mx;

    always @(posedge clk or negedge reset) begin
        m_sp = '0;
        m_hp = '0;
        m_rp = '0;
        if (!reset) begin
            rc = 0;
            for (int c = 0; c < 4; c++) begin
                lvl[c] = 0; held[c] = 0; run[c] = 0; hcnt[c] = 0;
            end
        end else begin
            hist[cyc] = btn_raw;
            for (int c = 0; c < 4; c++) begin
                mx  = (rc == 2 && cyc >= a + 2) ? hist[cyc-2][c] : 1'b0;
                pre = run[c];
                if (rc < 2 || !ch_en[c]) begin
                    lvl[c] = 0; held[c] = 0; run[c] = 0; hcnt[c] = 0;
                end else begin
                    if (lvl[c] && !held[c] && pre == 0 && mx && cyc - st[c] + 1 >= HT) begin
                        held[c] = 1; hcnt[c] = 0; m_hp[c] = 1'b1;
                    end else if (held[c] && pre == 0 && mx && RT > 0) begin
                        hcnt[c]++;
                        if (hcnt[c] == RT) begin hcnt[c] = 0; m_rp[c] = 1'b1; end
                    end
                    run[c] = (mx != lvl[c]) ? run[c] + 1 : 0;
                    if (!lvl[c] && run[c] == 1) st[c] = cyc;
                    if (run[c] == DB) begin
                        if (lvl[c]) begin m_sp[c] = !held[c]; held[c] = 0; end
                        lvl[c] = !lvl[c];
                        run[c] = 0;
                    end
                end
            end
            if (rc < 2) begin
                rc++;
                if (rc == 2) a = cyc + 1;
            end
        end
        for (int c = 0; c < 4; c++) begin
            m_pr[c] = lvl[c];
            m_hl[c] = held[c];
        end
    end

    // Per-cycle comparison against the model, plus a log of DUT events for the pinned checks
    int n_rise [4], rise_cyc [4], n_short [4], short_cyc [4];
    int n_hold [4], hold_cyc [4], n_rep [4], rep_first [4], rep_last [4];
    logic [3:0] prev_pr = '0;

    always @(negedge clk) begin
        vectors++;
        if ({pressed, short_pulse, hold_pulse, hold_level, repeat_pulse} !== {m_pr, m_sp, m_hp, m_hl, m_rp}) begin
            miscompares++;
            $display("FAIL outputs cyc=%0d got pr=%b sp=%b hp=%b hl=%b rp=%b expected pr=%b sp=%b hp=%b hl=%b rp=%b",
                     cyc, pressed, short_pulse, hold_pulse, hold_level, repeat_pulse, m_pr, m_sp, m_hp, m_hl, m_rp);
        end
        for (int c = 0; c < 4; c++) begin
            if (pressed[c] && !prev_pr[c]) begin n_rise[c]++; rise_cyc[c] = cyc; end
            if (short_pulse[c]) begin n_short[c]++; short_cyc[c] = cyc; end
            if (hold_pulse[c]) begin n_hold[c]++; hold_cyc[c] = cyc; end
            if (repeat_pulse[c]) begin
                n_rep[c]++;
                if (n_rep[c] == 1) rep_first[c] = cyc;
                rep_last[c] = cyc;
            end
        end
        prev_pr = pressed;
    end

    task automatic chk(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        int t, r, e;
        tick(3);
        chk("reset_outputs", int'({pressed, short_pulse, hold_pulse, hold_level, repeat_pulse}), 0);
        reset = 1'b1;
        tick(10);
        // 10-cycle blip on ch0 never qualifies
        btn_raw[0] = 1'b1; tick(10); btn_raw[0] = 1'b0; tick(40);
        chk("t1_no_press", n_rise[0], 0);
        chk("t1_no_short", n_short[0], 0);
        chk("t1_no_hold", n_hold[0], 0);
        // ch1 short press, ch2 plain hold, ch3 hold with repeats, all starting together
        t = cyc;
        btn_raw[3:1] = 3'b111;
        tick(1000); r = cyc; btn_raw[1] = 1'b0;
        tick(4000); btn_raw[2] = 1'b0;
        tick(1200); btn_raw[3] = 1'b0;
        tick(40);
        chk("t2_press_latency", rise_cyc[1] - t, 22);
        chk("t2_short_count", n_short[1], 1);
        chk("t2_short_latency", short_cyc[1] - r, 22);
        chk("t2_no_hold", n_hold[1], 0);
        chk("t3_hold_count", n_hold[2], 1);
        chk("t3_hold_time", hold_cyc[2] - t, 5002);
        chk("t3_no_short", n_short[2], 0);
        chk("t3_level_dropped", int'(hold_level[2]), 0);
        chk("t4_hold_same_cycle", hold_cyc[3], hold_cyc[2]);
        chk("t4_repeat_count", n_rep[3], 2);
        chk("t4_repeat_first", rep_first[3] - t, 5502);
        chk("t4_repeat_last", rep_last[3] - t, 6002);
        chk("t4_no_short", n_short[3], 0);
        // ch0 hold with a 5-cycle dropout at 3000
        t = cyc;
        btn_raw[0] = 1'b1; tick(3000); btn_raw[0] = 1'b0; tick(5); btn_raw[0] = 1'b1;
        tick(2000); btn_raw[0] = 1'b0; tick(40);
        chk("t5_single_press", n_rise[0], 1);
        chk("t5_hold_time", hold_cyc[0] - t, 5002);
        chk("t5_hold_count", n_hold[0], 1);
        chk("t5_no_short", n_short[0], 0);
        // reset pulse mid-hold on ch1, button kept down
        btn_raw[1] = 1'b1; tick(4000);
        chk("t6_pressed_before_reset", int'(pressed[1]), 1);
        reset = 1'b0;
        #1;
        chk("t6_outputs_cleared", int'({pressed, short_pulse, hold_pulse, hold_level, repeat_pulse}), 0);
        tick(5);
        reset = 1'b1; r = cyc;
        tick(5010);
        chk("t6_hold_after_reset", hold_cyc[1] - r, 5004);
        chk("t6_hold_count", n_hold[1], 1);
        btn_raw[1] = 1'b0; tick(40);
        chk("t6_no_new_short", n_short[1], 1);
        // ch2 disabled while held, then enabled: fresh debounce
        ch_en[2] = 1'b0; btn_raw[2] = 1'b1; tick(100);
        chk("t7_disabled_no_press", int'(pressed[2]), 0);
        e = n_rise[2];
        ch_en[2] = 1'b1; t = cyc; tick(40);
        chk("t7_enable_debounce", rise_cyc[2] - t, 20);
        chk("t7_one_new_press", n_rise[2] - e, 1);
        btn_raw[2] = 1'b0; tick(40);
        chk("t7_short_on_release", n_short[2], 1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
